// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 modified-Booth multiplier controller.
package booth_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECODE   = 3'd1,
    TOG_REQ  = 3'd2,
    TOG_WAIT = 3'd3,
    ACCUM    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // One Booth digit, value range -2..+2
  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t DIG_ZERO = 3'sb000;
  localparam booth_digit_t DIG_POS1 = 3'sb001;
  localparam booth_digit_t DIG_POS2 = 3'sb010;
  localparam booth_digit_t DIG_NEG1 = 3'sb111;
  localparam booth_digit_t DIG_NEG2 = 3'sb110;

  // Working width of pp_select; callers truncate to their word width.
  // Supports word widths up to PP_W-1 bits (BITLEN up to 30).
  localparam int PP_W = 64;

  // Select the unshifted partial product for one digit.
  // m is sign-extended M, neg_m is -M (modulo the caller's word width).
  function automatic logic [PP_W-1:0] pp_select(input booth_digit_t     digit,
                                                input logic [PP_W-1:0] m,
                                                input logic [PP_W-1:0] neg_m);
    logic [PP_W-1:0] pp;
    case (digit)
      DIG_POS1: pp = m;
      DIG_POS2: pp = {m[PP_W-2:0], 1'b0};
      DIG_NEG1: pp = neg_m;
      DIG_NEG2: pp = {neg_m[PP_W-2:0], 1'b0};
      default:  pp = {PP_W{1'b0}};
    endcase
    return pp;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational radix-4 Booth recoder: Y -> NDIG signed digits plus a
// flag telling whether any digit needs the negated multiplicand.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int BITLEN = 4
) (
  input  logic [BITLEN-1:0]         y,
  output logic [3*(BITLEN/2)-1:0]   digits,
  output logic                      any_neg
);

  localparam int NDIG = BITLEN / 2;

  // y_ext[0] is the implicit Y[-1] = 0, so triplet i sits at y_ext[2i+2:2i]
  logic [BITLEN:0] y_ext;
  assign y_ext = {y, 1'b0};

  // Map each overlapping triplet to its Booth digit and collect negative digits
  always_comb begin
    booth_digit_t d;
    d       = DIG_ZERO;
    digits  = {(3*NDIG){1'b0}};
    any_neg = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      case (y_ext[2*i +: 3])
        3'b001, 3'b010: d = DIG_POS1;
        3'b011:         d = DIG_POS2;
        3'b100:         d = DIG_NEG2;
        3'b101, 3'b110: d = DIG_NEG1;
        default:        d = DIG_ZERO;
      endcase
      digits[3*i +: 3] = d;
      any_neg          = any_neg | d[2];
    end
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencing controller for the radix-4 modified-Booth signed multiplier.
// -M is obtained from the shared word-toggle unit (one's complement) plus 1.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int BITLEN      = 4,
  parameter int TOG_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_pulse,
  input  logic [BITLEN-1:0]     multiplicand,
  input  logic [BITLEN-1:0]     multiplier,
  output logic                  busy,
  output logic [2*BITLEN-1:0]   product,
  output logic                  product_valid_pulse,
  output logic                  err,
  output logic [2*BITLEN-1:0]   tog_in,
  output logic                  tog_valid_pulse,
  input  logic                  tog_busy,
  input  logic [2*BITLEN-1:0]   tog_out,
  input  logic                  tog_out_valid_pulse
);

  localparam int NDIG   = BITLEN / 2;
  localparam int TOG_W  = 2 * BITLEN;
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int TCNT_W = $clog2(TOG_TIMEOUT + 1);

  state_t state, state_nxt;

  logic [BITLEN-1:0] m_reg, m_nxt;
  logic [BITLEN-1:0] y_reg, y_nxt;
  logic [3*NDIG-1:0] digits_reg, digits_nxt;
  logic [TOG_W-1:0]  acc, acc_nxt;
  logic [TOG_W-1:0]  neg_m, neg_m_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;

  logic              busy_nxt;
  logic [TOG_W-1:0]  product_nxt;
  logic              pvp_nxt;
  logic              err_nxt;
  logic [TOG_W-1:0]  tog_in_nxt;
  logic              tog_vp_nxt;

  logic [3*NDIG-1:0] rec_digits;
  logic              rec_any_neg;

  booth_recoder #(.BITLEN(BITLEN)) u_recoder (
    .y       (y_reg),
    .digits  (rec_digits),
    .any_neg (rec_any_neg)
  );

  // Partial-product datapath for the digit currently being accumulated
  booth_digit_t      cur_digit;
  logic [PP_W-1:0]   m_wide;
  logic [PP_W-1:0]   neg_wide;
  logic [PP_W-1:0]   pp_wide;
  logic [TOG_W-1:0]  pp_word;
  logic [TOG_W-1:0]  pp_shift;
  logic [TOG_W-1:0]  m_sext;

  assign cur_digit = booth_digit_t'(digits_reg[3*int'(idx) +: 3]);
  assign m_wide    = {{(PP_W-BITLEN){m_reg[BITLEN-1]}}, m_reg};
  assign neg_wide  = {{(PP_W-TOG_W){1'b0}}, neg_m};
  assign pp_wide   = pp_select(cur_digit, m_wide, neg_wide);
  assign pp_word   = pp_wide[TOG_W-1:0];
  assign pp_shift  = pp_word << (2 * int'(idx));
  assign m_sext    = {{BITLEN{m_reg[BITLEN-1]}}, m_reg};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for every registered signal
  always_comb begin
    state_nxt   = state;
    m_nxt       = m_reg;
    y_nxt       = y_reg;
    digits_nxt  = digits_reg;
    acc_nxt     = acc;
    neg_m_nxt   = neg_m;
    idx_nxt     = idx;
    tcnt_nxt    = tcnt;
    busy_nxt    = busy;
    product_nxt = product;
    pvp_nxt     = 1'b0;
    err_nxt     = err;
    tog_in_nxt  = tog_in;
    tog_vp_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start_pulse) begin
          m_nxt     = multiplicand;
          y_nxt     = multiplier;
          acc_nxt   = {TOG_W{1'b0}};
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = RECODE;
        end else begin
          state_nxt = IDLE;
        end
      end

      RECODE: begin
        digits_nxt = rec_digits;
        idx_nxt    = {IDX_W{1'b0}};
        if (rec_any_neg) begin
          state_nxt = TOG_REQ;
        end else begin
          state_nxt = ACCUM;
        end
      end

      TOG_REQ: begin
        if (tog_busy) begin
          state_nxt = TOG_REQ;
        end else begin
          tog_in_nxt = m_sext;
          tog_vp_nxt = 1'b1;
          tcnt_nxt   = {TCNT_W{1'b0}};
          state_nxt  = TOG_WAIT;
        end
      end

      TOG_WAIT: begin
        if (tog_out_valid_pulse) begin
          neg_m_nxt = tog_out + TOG_W'(1);
          idx_nxt   = {IDX_W{1'b0}};
          state_nxt = ACCUM;
        end else if (tcnt == TCNT_W'(TOG_TIMEOUT - 1)) begin
          // Counter reaches TOG_TIMEOUT on this cycle: give up
          tcnt_nxt    = tcnt + TCNT_W'(1);
          err_nxt     = 1'b1;
          product_nxt = {TOG_W{1'b0}};
          state_nxt   = DONE;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end

      ACCUM: begin
        acc_nxt = acc + pp_shift;
        if (idx == IDX_W'(NDIG - 1)) begin
          product_nxt = acc + pp_shift;
          state_nxt   = DONE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      DONE: begin
        pvp_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_reg               <= {BITLEN{1'b0}};
      y_reg               <= {BITLEN{1'b0}};
      digits_reg          <= {(3*NDIG){1'b0}};
      acc                 <= {TOG_W{1'b0}};
      neg_m               <= {TOG_W{1'b0}};
      idx                 <= {IDX_W{1'b0}};
      tcnt                <= {TCNT_W{1'b0}};
      busy                <= 1'b0;
      product             <= {TOG_W{1'b0}};
      product_valid_pulse <= 1'b0;
      err                 <= 1'b0;
      tog_in              <= {TOG_W{1'b0}};
      tog_valid_pulse     <= 1'b0;
    end else begin
      m_reg               <= m_nxt;
      y_reg               <= y_nxt;
      digits_reg          <= digits_nxt;
      acc                 <= acc_nxt;
      neg_m               <= neg_m_nxt;
      idx                 <= idx_nxt;
      tcnt                <= tcnt_nxt;
      busy                <= busy_nxt;
      product             <= product_nxt;
      product_valid_pulse <= pvp_nxt;
      err                 <= err_nxt;
      tog_in              <= tog_in_nxt;
      tog_valid_pulse     <= tog_vp_nxt;
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl with a behavioural word-toggle unit.
module tb_booth_mult_ctrl;

  localparam int BITLEN = 4;
  localparam int TOG_W  = 2 * BITLEN;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start_pulse = 1'b0;
  logic [BITLEN-1:0] multiplicand = '0;
  logic [BITLEN-1:0] multiplier = '0;
  logic              busy;
  logic [TOG_W-1:0]  product;
  logic              product_valid_pulse;
  logic              err;
  logic [TOG_W-1:0]  tog_in;
  logic              tog_valid_pulse;
  logic              tog_busy = 1'b0;
  logic [TOG_W-1:0]  tog_out = '0;
  logic              tog_out_valid_pulse;
  logic              model_strobe = 1'b0;
  logic              manual_strobe = 1'b0;
  bit                tog_respond = 1'b1;

  assign tog_out_valid_pulse = model_strobe | manual_strobe;

  booth_mult_ctrl #(.BITLEN(BITLEN), .TOG_TIMEOUT(15)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .start_pulse         (start_pulse),
    .multiplicand        (multiplicand),
    .multiplier          (multiplier),
    .busy                (busy),
    .product             (product),
    .product_valid_pulse (product_valid_pulse),
    .err                 (err),
    .tog_in              (tog_in),
    .tog_valid_pulse     (tog_valid_pulse),
    .tog_busy            (tog_busy),
    .tog_out             (tog_out),
    .tog_out_valid_pulse (tog_out_valid_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TOG_W-1:0] prod;
    logic             err;
    int               ntog;
    logic [TOG_W-1:0] tog_exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tog_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference product by plain signed multiplication
  function automatic logic [TOG_W-1:0] ref_prod(input logic [BITLEN-1:0] m, input logic [BITLEN-1:0] y);
    int a, b, p;
    a = $signed(m);
    b = $signed(y);
    p = a * b;
    return p[TOG_W-1:0];
  endfunction

  // 1 if any Booth digit d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1] is negative
  function automatic int exp_ntog(input logic [BITLEN-1:0] y);
    logic [BITLEN:0] ye;
    int d, n;
    ye = {y, 1'b0};
    n  = 0;
    for (int i = 0; i < BITLEN / 2; i++) begin
      d = -2 * int'(ye[2*i+2]) + int'(ye[2*i+1]) + int'(ye[2*i]);
      if (d < 0) n = 1;
    end
    return n;
  endfunction

  // Push the expectation and pulse start for one cycle (called at posedge+1)
  task automatic issue(input logic [BITLEN-1:0] m, input logic [BITLEN-1:0] y, input logic err_exp);
    exp_t e;
    e.prod    = err_exp ? 8'h00 : ref_prod(m, y);
    e.err     = err_exp;
    e.ntog    = exp_ntog(y);
    e.tog_exp = {{BITLEN{m[BITLEN-1]}}, m};
    sb.push_back(e);
    multiplicand = m;
    multiplier   = y;
    start_pulse  = 1'b1;
    @(posedge clock);
    #1 start_pulse = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: count toggle requests, compare results against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        tog_seen = 0;
      end else begin
        if (tog_valid_pulse === 1'b1) begin
          tog_seen++;
          if (sb.size() > 0) check("tog_in", tog_in, sb[0].tog_exp);
        end
        if (product_valid_pulse === 1'b1) begin
          if (sb.size() == 0) begin
            check("spurious_result", product_valid_pulse, 64'd0);
          end else begin
            e = sb.pop_front();
            check("product", product, e.prod);
            check("err", err, e.err);
            check("busy_at_result", busy, 64'd0);
            check("tog_count", 64'(tog_seen), 64'(e.ntog));
          end
          tog_seen = 0;
        end
      end
    end
  end

  // Toggle unit model: result strobe sampled 3 edges after the request edge
  initial begin
    logic [TOG_W-1:0] cap;
    forever begin
      @(negedge clock);
      if (tog_valid_pulse === 1'b1 && tog_respond) begin
        cap = ~tog_in;
        repeat (2) @(posedge clock);
        #1;
        tog_out      = cap;
        model_strobe = 1'b1;
        @(posedge clock);
        #1 model_strobe = 1'b0;
      end
    end
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_pvp", product_valid_pulse, 64'd0);
    check("rst_err", err, 64'd0);
    check("rst_tog_in", tog_in, 64'd0);
    check("rst_tog_vp", tog_valid_pulse, 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 1: no toggle, exact latency
    issue(4'd3, 4'd1, 1'b0);
    repeat (4) @(negedge clock);
    check("lat_before_edge4", product_valid_pulse, 64'd0);
    check("busy_during_op", busy, 64'd1);
    @(negedge clock);
    check("lat_edge4", product_valid_pulse, 64'd1);
    @(posedge clock);
    #1;
    wait_done();

    // 2: -2 digit needs the toggle unit
    issue(4'd3, 4'd2, 1'b0);
    wait_done();

    // 3: extreme operands
    issue(4'h8, 4'h8, 1'b0);
    wait_done();
    issue(4'h8, 4'h7, 1'b0);
    wait_done();

    // 4: tog_busy stalls the request
    tog_busy = 1'b1;
    issue(4'd3, 4'd2, 1'b0);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    check("tog_held_by_busy", 64'(tog_seen), 64'd0);
    tog_busy = 1'b0;
    wait_done();

    // 5: toggle never answers -> timeout, then stale strobe, then err clears
    tog_respond = 1'b0;
    issue(4'd3, 4'd2, 1'b1);
    wait_done();
    manual_strobe = 1'b1;
    @(posedge clock);
    #1 manual_strobe = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("stale_busy", busy, 64'd0);
    check("stale_product", product, 64'd0);
    check("err_held", err, 64'd1);
    tog_respond = 1'b1;
    issue(4'd3, 4'd1, 1'b0);
    check("err_cleared", err, 64'd0);
    wait_done();

    // 6: reset during TOG_WAIT, then a start during ACCUM is ignored
    tog_respond = 1'b0;
    issue(4'd3, 4'd2, 1'b0);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", busy, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_pvp", product_valid_pulse, 64'd0);
    check("abort_err", err, 64'd0);
    check("abort_tog_in", tog_in, 64'd0);
    check("abort_tog_vp", tog_valid_pulse, 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    tog_respond = 1'b1;
    issue(4'h8, 4'h7, 1'b0);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    multiplicand = 4'd3;
    multiplier   = 4'd1;
    start_pulse  = 1'b1;
    @(posedge clock);
    #1 start_pulse = 1'b0;
    check("busy_mid_start", busy, 64'd1);
    wait_done();
    repeat (10) begin
      @(posedge clock);
      #1;
    end

    // Exhaustive operand sweep
    for (int m = 0; m < 16; m++) begin
      for (int y = 0; y < 16; y++) begin
        issue(4'(m), 4'(y), 1'b0);
        wait_done();
      end
    end
    repeat (5) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
